// File: rtl/egg_timer_pkg.sv
// Shared egg-timer definitions: alarm FSM states, tone codes and default 500 Hz tick constants.
package egg_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_BEEP_ON,
    ST_BEEP_OFF,
    ST_FINISH
  } alarm_state_t;

  localparam logic TONE_LOW  = 1'b0;
  localparam logic TONE_HIGH = 1'b1;

  localparam int TICK_BASE_HZ         = 500;
  localparam int DEFAULT_BEEP_TICKS   = TICK_BASE_HZ / 2;  // 0.5 s at the 500 Hz tick
  localparam int DEFAULT_BEEP_REPEATS = 10;
  localparam int DEFAULT_TICK_CNT_W   = 9;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_tick_counter.sv
// Tick counter with synchronous clear and enable; tc flags the enabled tick that lands on term.
// The count wraps to zero on that tick, so one instance can time successive phases.
module alarm_tick_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = en && (count == term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/egg_alarm_sequencer.sv
// End-of-cook alarm: beeps on a 00:00 edge until the repeat limit or a stop, then pulses cook_done.
// ALARM_MIC_STOP_EN makes a mic_trigger pulse stop the alarm like stop_req.
module egg_alarm_sequencer
  import egg_timer_pkg::*;
#(
  parameter int BEEP_ON_TICKS  = DEFAULT_BEEP_TICKS,
  parameter int BEEP_OFF_TICKS = DEFAULT_BEEP_TICKS,
  parameter int BEEP_REPEATS   = DEFAULT_BEEP_REPEATS,
  parameter int TICK_CNT_W     = DEFAULT_TICK_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_500hz,
  input  logic       countdown_active,
  input  logic       time_zero,
  input  logic       stop_req,
  input  logic       mic_trigger,
  output logic       audio_en,
  output logic       tone_sel,
  output logic       alarm_active,
  output logic [3:0] beep_count,
  output logic       cook_done
);

  alarm_state_t          state, next_state;
  logic                  tz_prev, tz_edge;
  logic                  in_beep, stop_hit, mic_stop, tc;
  logic [TICK_CNT_W-1:0] term;
  logic [3:0]            next_beep_count;
  logic                  next_tone_sel;

`ifdef ALARM_MIC_STOP_EN
  assign mic_stop = mic_trigger;
`else
  logic unused_mic;
  assign unused_mic = mic_trigger;
  assign mic_stop   = 1'b0;
`endif

  assign in_beep  = (state == ST_BEEP_ON) || (state == ST_BEEP_OFF);
  assign stop_hit = in_beep && (stop_req || mic_stop);
  assign term     = (state == ST_BEEP_OFF) ? TICK_CNT_W'(BEEP_OFF_TICKS - 1)
                                           : TICK_CNT_W'(BEEP_ON_TICKS - 1);

  alarm_tick_counter #(
    .W(TICK_CNT_W)
  ) u_tick_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!in_beep || stop_hit),
    .en    (in_beep && tick_500hz),
    .term  (term),
    .tc    (tc)
  );

  // Edge is only captured while ARMED so a time already at 00:00 when arming never rings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tz_prev <= 1'b0;
      tz_edge <= 1'b0;
    end else begin
      tz_prev <= time_zero;
      tz_edge <= (state == ST_ARMED) && time_zero && !tz_prev;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      beep_count   <= 4'd0;
      tone_sel     <= TONE_LOW;
      audio_en     <= 1'b0;
      alarm_active <= 1'b0;
      cook_done    <= 1'b0;
    end else begin
      state        <= next_state;
      beep_count   <= next_beep_count;
      tone_sel     <= next_tone_sel;
      audio_en     <= (next_state == ST_BEEP_ON);
      alarm_active <= (next_state == ST_BEEP_ON) || (next_state == ST_BEEP_OFF);
      cook_done    <= (state == ST_FINISH);
    end
  end

  always_comb begin
    next_state      = state;
    next_beep_count = beep_count;
    next_tone_sel   = tone_sel;
    case (state)
      ST_IDLE: begin
        if (countdown_active) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (tz_edge) begin
          next_state      = ST_BEEP_ON;
          next_beep_count = 4'd1;
          next_tone_sel   = TONE_LOW;
        end else if (!countdown_active) begin
          next_state = ST_IDLE;
        end
      end
      ST_BEEP_ON: begin
        if (stop_hit)  next_state = ST_FINISH;
        else if (tc)   next_state = ST_BEEP_OFF;
      end
      ST_BEEP_OFF: begin
        if (stop_hit) begin
          next_state = ST_FINISH;
        end else if (tc) begin
          if (beep_count == 4'(BEEP_REPEATS)) begin
            next_state = ST_FINISH;
          end else begin
            next_state      = ST_BEEP_ON;
            next_beep_count = sat_inc4(beep_count);
            next_tone_sel   = (tone_sel == TONE_LOW) ? TONE_HIGH : TONE_LOW;
          end
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_egg_alarm_sequencer.sv
// Directed bench for egg_alarm_sequencer with 4 on / 3 off ticks, 2 repeats, a tick every 5 clk.
module tb_egg_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick_500hz, countdown_active, time_zero, stop_req, mic_trigger;
  logic       audio_en, tone_sel, alarm_active, cook_done;
  logic [3:0] beep_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   on_ticks, off_ticks, beeps_seen, done_cnt;
  logic prev_audio;
  logic [1:0] beep_tones;

  always #5 clk = ~clk;

  egg_alarm_sequencer #(
    .BEEP_ON_TICKS  (4),
    .BEEP_OFF_TICKS (3),
    .BEEP_REPEATS   (2),
    .TICK_CNT_W     (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tick_500hz       (tick_500hz),
    .countdown_active (countdown_active),
    .time_zero        (time_zero),
    .stop_req         (stop_req),
    .mic_trigger      (mic_trigger),
    .audio_en         (audio_en),
    .tone_sel         (tone_sel),
    .alarm_active     (alarm_active),
    .beep_count       (beep_count),
    .cook_done        (cook_done)
  );

  // Advance to the next falling edge, drive the tick, and tally what the DUT shows.
  // A tick driven here is consumed at the next rising edge by the state now visible.
  task automatic next();
    @(negedge clk);
    cyc++;
    tick_500hz = (cyc % 5 == 0);
    if (audio_en && tick_500hz) on_ticks++;
    if (alarm_active && !audio_en && tick_500hz) off_ticks++;
    if (audio_en && !prev_audio) begin
      if (beeps_seen < 2) beep_tones[beeps_seen] = tone_sel;
      beeps_seen++;
    end
    prev_audio = audio_en;
    if (cook_done) done_cnt++;
  endtask

  task automatic clear_stats();
    on_ticks = 0; off_ticks = 0; beeps_seen = 0; done_cnt = 0;
    prev_audio = 1'b0; beep_tones = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1; countdown_active = 1'b0; time_zero = 1'b0;
    stop_req = 1'b0; mic_trigger = 1'b0; tick_500hz = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    next();
    clear_stats();
  endtask

  task automatic start_alarm();
    countdown_active = 1'b1;
    next(); next();
    time_zero = 1'b1;
    next(); next();
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == 0; i++) next();
    vectors++;
    if (done_cnt == 0) begin miscompares++; $display("FAIL %s_timeout: cook_done seen %0d times, want at least 1", tag, done_cnt); end
  endtask

  task automatic wait_on_ticks(input int n, input string tag);
    for (int i = 0; i < 200 && on_ticks < n; i++) next();
    vectors++;
    if (on_ticks != n) begin miscompares++; $display("FAIL %s_reach_tick: on_ticks %0d, want %0d", tag, on_ticks, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1; countdown_active = 1'b0; time_zero = 1'b0;
    stop_req = 1'b0; mic_trigger = 1'b0; tick_500hz = 1'b0;
    #1;
    vectors++; if (audio_en !== 1'b0)     begin miscompares++; $display("FAIL rst_audio_en: got %b want 0", audio_en); end
    vectors++; if (tone_sel !== 1'b0)     begin miscompares++; $display("FAIL rst_tone_sel: got %b want 0", tone_sel); end
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL rst_alarm_active: got %b want 0", alarm_active); end
    vectors++; if (beep_count !== 4'd0)   begin miscompares++; $display("FAIL rst_beep_count: got %0d want 0", beep_count); end
    vectors++; if (cook_done !== 1'b0)    begin miscompares++; $display("FAIL rst_cook_done: got %b want 0", cook_done); end
  endtask

  task automatic test_full_pattern();
    do_reset();
    countdown_active = 1'b1;
    next(); next();
    time_zero = 1'b1;
    next();
    vectors++; if (audio_en !== 1'b0) begin miscompares++; $display("FAIL full_lat1: audio_en %b want 0", audio_en); end
    next();
    vectors++; if (audio_en !== 1'b1)   begin miscompares++; $display("FAIL full_lat2: audio_en %b want 1", audio_en); end
    vectors++; if (beep_count !== 4'd1) begin miscompares++; $display("FAIL full_first_count: got %0d want 1", beep_count); end
    vectors++; if (tone_sel !== 1'b0)   begin miscompares++; $display("FAIL full_first_tone: got %b want 0", tone_sel); end
    wait_done(300, "full");
    time_zero = 1'b0; countdown_active = 1'b0;
    repeat (3) next();
    vectors++; if (on_ticks != 8)         begin miscompares++; $display("FAIL full_on_ticks: got %0d want 8", on_ticks); end
    vectors++; if (off_ticks != 6)        begin miscompares++; $display("FAIL full_off_ticks: got %0d want 6", off_ticks); end
    vectors++; if (beeps_seen != 2)       begin miscompares++; $display("FAIL full_beeps: got %0d want 2", beeps_seen); end
    vectors++; if (beep_tones !== 2'b10)  begin miscompares++; $display("FAIL full_tones: got %b want 10", beep_tones); end
    vectors++; if (done_cnt != 1)         begin miscompares++; $display("FAIL full_done_width: got %0d want 1", done_cnt); end
    vectors++; if (beep_count !== 4'd2)   begin miscompares++; $display("FAIL full_beep_count: got %0d want 2", beep_count); end
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL full_idle_after: alarm_active %b want 0", alarm_active); end
  endtask

  task automatic test_button_stop();
    do_reset();
    start_alarm();
    wait_on_ticks(2, "btn");
    stop_req = 1'b1;
    next();
    vectors++; if (audio_en !== 1'b0)     begin miscompares++; $display("FAIL btn_audio_off: got %b want 0", audio_en); end
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL btn_alarm_off: got %b want 0", alarm_active); end
    vectors++; if (cook_done !== 1'b0)    begin miscompares++; $display("FAIL btn_done_early: got %b want 0", cook_done); end
    next();
    vectors++; if (cook_done !== 1'b1)    begin miscompares++; $display("FAIL btn_done: got %b want 1", cook_done); end
    vectors++; if (beep_count !== 4'd1)   begin miscompares++; $display("FAIL btn_beep_count: got %0d want 1", beep_count); end
    stop_req = 1'b0; time_zero = 1'b0; countdown_active = 1'b0;
    next();
    vectors++; if (cook_done !== 1'b0)    begin miscompares++; $display("FAIL btn_done_width: got %b want 0", cook_done); end
  endtask

  task automatic test_collision();
    do_reset();
    start_alarm();
    wait_on_ticks(4, "coll");
    stop_req = 1'b1;
    next();
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL coll_not_off: alarm_active %b want 0", alarm_active); end
    next();
    vectors++; if (cook_done !== 1'b1)    begin miscompares++; $display("FAIL coll_done: got %b want 1", cook_done); end
    vectors++; if (off_ticks != 0)        begin miscompares++; $display("FAIL coll_off_ticks: got %0d want 0", off_ticks); end
    stop_req = 1'b0; time_zero = 1'b0; countdown_active = 1'b0;
    next();
  endtask

  task automatic test_mic_stop();
    do_reset();
    start_alarm();
    for (int i = 0; i < 200 && !(alarm_active && !audio_en); i++) next();
    vectors++;
    if (!(alarm_active && !audio_en)) begin miscompares++; $display("FAIL mic_reach_off: alarm_active %b audio_en %b want 1 0", alarm_active, audio_en); end
    mic_trigger = 1'b1;
    next();
    mic_trigger = 1'b0;
`ifdef ALARM_MIC_STOP_EN
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL mic_stop: alarm_active %b want 0", alarm_active); end
    next();
    vectors++; if (cook_done !== 1'b1)    begin miscompares++; $display("FAIL mic_done: got %b want 1", cook_done); end
    vectors++; if (beep_count !== 4'd1)   begin miscompares++; $display("FAIL mic_beep_count: got %0d want 1", beep_count); end
`else
    vectors++; if (alarm_active !== 1'b1) begin miscompares++; $display("FAIL mic_ignored: alarm_active %b want 1", alarm_active); end
    wait_done(300, "mic");
    vectors++; if (beep_count !== 4'd2)   begin miscompares++; $display("FAIL mic_full_count: got %0d want 2", beep_count); end
    vectors++; if (on_ticks != 8)         begin miscompares++; $display("FAIL mic_full_on_ticks: got %0d want 8", on_ticks); end
`endif
    time_zero = 1'b0; countdown_active = 1'b0;
    repeat (2) next();
  endtask

  task automatic test_guards();
    do_reset();
    time_zero = 1'b1;
    stop_req = 1'b1;
    repeat (20) next();
    countdown_active = 1'b1;
    repeat (20) next();
    vectors++; if (beeps_seen != 0) begin miscompares++; $display("FAIL guard_idle_zero: beeps %0d want 0", beeps_seen); end
    stop_req = 1'b0;
    time_zero = 1'b0;
    repeat (3) next();
    countdown_active = 1'b0;
    repeat (3) next();
    time_zero = 1'b1;
    repeat (20) next();
    vectors++; if (beeps_seen != 0) begin miscompares++; $display("FAIL guard_abort_idle: beeps %0d want 0", beeps_seen); end
    vectors++; if (done_cnt != 0)   begin miscompares++; $display("FAIL guard_abort_done: cook_done count %0d want 0", done_cnt); end
    time_zero = 1'b0;
    countdown_active = 1'b1;
    next(); next();
    stop_req = 1'b1;
    next();
    stop_req = 1'b0;
    time_zero = 1'b1;
    next(); next();
    vectors++; if (audio_en !== 1'b1) begin miscompares++; $display("FAIL guard_armed_stop: audio_en %b want 1", audio_en); end
  endtask

  task automatic test_reset_mid_beep();
    do_reset();
    start_alarm();
    wait_on_ticks(1, "rst");
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (audio_en !== 1'b0)     begin miscompares++; $display("FAIL rstmid_audio_en: got %b want 0", audio_en); end
    vectors++; if (alarm_active !== 1'b0) begin miscompares++; $display("FAIL rstmid_alarm_active: got %b want 0", alarm_active); end
    vectors++; if (beep_count !== 4'd0)   begin miscompares++; $display("FAIL rstmid_beep_count: got %0d want 0", beep_count); end
    vectors++; if (tone_sel !== 1'b0)     begin miscompares++; $display("FAIL rstmid_tone_sel: got %b want 0", tone_sel); end
    vectors++; if (cook_done !== 1'b0)    begin miscompares++; $display("FAIL rstmid_cook_done: got %b want 0", cook_done); end
    time_zero = 1'b0; countdown_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (30) next();
    vectors++; if (done_cnt != 0)   begin miscompares++; $display("FAIL rstmid_no_done: cook_done count %0d want 0", done_cnt); end
    vectors++; if (beeps_seen != 0) begin miscompares++; $display("FAIL rstmid_no_beep: beeps %0d want 0", beeps_seen); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_full_pattern();
    test_button_stop();
    test_collision();
    test_mic_stop();
    test_guards();
    test_reset_mid_beep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
